// File: rtl/spi_config_regs.sv
// Addressed SPI configuration bank for the FM transmitter. SPI pins are
// oversampled in the clk domain; writes commit atomically on CSn rise.
module spi_config_regs #(
    parameter int NREG = 4,
    parameter int AW = 2,
    parameter int RW = 24,
    parameter logic [NREG*RW-1:0] DEFAULTS = {NREG*RW{1'b0}}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spi_clk,
    input  logic                 spi_csn,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic [NREG*RW-1:0]   cfg_out,
    output logic                 cfg_update,
    output logic [AW-1:0]        cfg_addr,
    output logic                 frame_err
);
    localparam int FL = 1 + AW + RW;
    localparam int CW = $clog2(FL + 2);
    localparam logic [CW-1:0] CNT_HDR_LAST = CW'(AW);
    localparam logic [CW-1:0] CNT_DATA0    = CW'(1 + AW);
    localparam logic [CW-1:0] CNT_FL       = CW'(FL);
    localparam logic [CW-1:0] CNT_OVR      = CW'(FL + 1);

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t              state_q, state_d;
    logic [2:0]          sck_sync_q, sck_sync_d;
    logic [2:0]          csn_sync_q, csn_sync_d;
    logic [1:0]          mosi_sync_q, mosi_sync_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [AW:0]         hdr_q, hdr_d;
    logic [RW-1:0]       stage_q, stage_d;
    logic [RW-1:0]       rd_q, rd_d;
    logic                miso_q, miso_d;
    logic [NREG*RW-1:0]  bank_q, bank_d;
    logic                upd_q, upd_d;
    logic                err_q, err_d;
    logic [AW-1:0]       caddr_q, caddr_d;

    logic                sck_rise, sck_fall, csn_rise, csn_fall, mosi_s;
    logic [AW:0]         hdr_n;
    logic [RW-1:0]       rd_lookup;
    logic                addr_ok;

    // [1] is the synced level, [2] the previous synced level
    assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
    assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
    assign csn_rise = csn_sync_q[1] & ~csn_sync_q[2];
    assign csn_fall = ~csn_sync_q[1] & csn_sync_q[2];
    assign mosi_s   = mosi_sync_q[1];
    assign hdr_n    = {hdr_q[AW-1:0], mosi_s};
    assign addr_ok  = int'(hdr_q[AW-1:0]) < NREG;

    always_comb begin
        sck_sync_d  = {sck_sync_q[1:0], spi_clk};
        csn_sync_d  = {csn_sync_q[1:0], spi_csn};
        mosi_sync_d = {mosi_sync_q[0], spi_mosi};
    end

    // Read word for the address completed by the current header rise
    always_comb begin
        rd_lookup = '0;
        for (int i = 0; i < NREG; i++)
            if (int'(hdr_n[AW-1:0]) == i) rd_lookup = bank_q[i*RW +: RW];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sck_sync_q  <= 3'b000;
            csn_sync_q  <= 3'b111;
            mosi_sync_q <= 2'b00;
            cnt_q       <= '0;
            hdr_q       <= '0;
            stage_q     <= '0;
            rd_q        <= '0;
            miso_q      <= 1'b0;
            bank_q      <= DEFAULTS;
            upd_q       <= 1'b0;
            err_q       <= 1'b0;
            caddr_q     <= '0;
        end else begin
            state_q     <= state_d;
            sck_sync_q  <= sck_sync_d;
            csn_sync_q  <= csn_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cnt_q       <= cnt_d;
            hdr_q       <= hdr_d;
            stage_q     <= stage_d;
            rd_q        <= rd_d;
            miso_q      <= miso_d;
            bank_q      <= bank_d;
            upd_q       <= upd_d;
            err_q       <= err_d;
            caddr_q     <= caddr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (csn_fall) state_d = HDR;
            HDR:     if (csn_rise) state_d = IDLE;
                     else if (sck_rise && cnt_q == CNT_HDR_LAST) state_d = DATA;
            DATA:    if (csn_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        hdr_d   = hdr_q;
        stage_d = stage_q;
        rd_d    = rd_q;
        miso_d  = miso_q;
        bank_d  = bank_q;
        upd_d   = 1'b0;
        err_d   = 1'b0;
        caddr_d = caddr_q;
        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (csn_fall) cnt_d = '0;
            end
            HDR: begin
                if (csn_rise) begin
                    err_d  = 1'b1;
                    miso_d = 1'b0;
                end else if (sck_rise) begin
                    hdr_d = hdr_n;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_HDR_LAST) begin
                        rd_d   = rd_lookup;
                        miso_d = rd_lookup[RW-1];
                    end
                end
            end
            DATA: begin
                if (csn_rise) begin
                    miso_d = 1'b0;
                    if (cnt_q == CNT_FL && hdr_q[AW] && addr_ok) begin
                        for (int i = 0; i < NREG; i++)
                            if (int'(hdr_q[AW-1:0]) == i) bank_d[i*RW +: RW] = stage_q;
                        upd_d   = 1'b1;
                        caddr_d = hdr_q[AW-1:0];
                    end else if (!(cnt_q == CNT_FL && !hdr_q[AW])) begin
                        err_d = 1'b1;
                    end
                end else begin
                    if (sck_rise) begin
                        stage_d = {stage_q[RW-2:0], mosi_s};
                        if (cnt_q != CNT_OVR) cnt_d = cnt_q + CW'(1);
                    end
                    // The fall closing the last header bit must not shift: the MSB
                    // has to stay on MISO until the first data rise.
                    if (sck_fall && cnt_q > CNT_DATA0) begin
                        rd_d   = {rd_q[RW-2:0], 1'b0};
                        miso_d = rd_q[RW-2];
                    end
                end
            end
            default: ;
        endcase
    end

    assign spi_miso   = miso_q;
    assign cfg_out    = bank_q;
    assign cfg_update = upd_q;
    assign cfg_addr   = caddr_q;
    assign frame_err  = err_q;
endmodule

// File: tb/tb_spi_config_regs.sv
// Bench for spi_config_regs: table of SPI frames against a small bank model,
// with commit/error pulses checked by a scoreboard queue.
module tb_spi_config_regs;
    localparam logic [95:0] DEF = {24'h00001F, 24'h000000, 24'h000000, 24'h0CCCCC};
    localparam int K_NONE = 0, K_ERR = 1, K_UPD = 2;

    logic        clk = 1'b0, rst = 1'b1;
    logic        spi_clk = 1'b0, spi_csn = 1'b1, spi_mosi = 1'b0;
    logic        spi_miso, cfg_update, frame_err;
    logic [95:0] cfg_out;
    logic [1:0]  cfg_addr;

    spi_config_regs #(.NREG(4), .AW(2), .RW(24), .DEFAULTS(DEF)) dut (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_csn(spi_csn),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .cfg_out(cfg_out),
        .cfg_update(cfg_update), .cfg_addr(cfg_addr), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int     checks = 0, errors = 0;
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;
        logic [1:0]  addr;
        logic [95:0] bank;
        longint      cyc;
    } ev_t;
    ev_t sb[$];
    ev_t mon_e;

    typedef struct {
        bit          w;
        logic [1:0]  addr;
        logic [23:0] data;
        int          nbits;
        int          kind;
        logic [23:0] exp_rd;
    } vec_t;
    vec_t vecs[12];

    logic [95:0] bank_m;
    logic [23:0] rd;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cfg_update || frame_err) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got upd=%0b err=%0b expected none at cycle %0d",
                         cfg_update, frame_err, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("pulse_kind", 96'({cfg_update, frame_err}), 96'(mon_e.kind));
                chk("pulse_cycle", 96'(cyc), 96'(mon_e.cyc));
                if (mon_e.kind == K_UPD) chk("cfg_addr", 96'(cfg_addr), 96'(mon_e.addr));
                chk("cfg_out_at_pulse", cfg_out, mon_e.bank);
            end
        end
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit w, input logic [1:0] a, input logic [23:0] d,
                              input int nbits, input int rst_at, input int kind,
                              input logic [95:0] exp_bank, output logic [23:0] rd_o);
        logic [26:0] f;
        f    = {w, a, d};
        rd_o = '0;
        wclk(1);
        spi_csn = 1'b0;
        wclk(4);
        for (int k = 0; k < nbits; k++) begin
            if (k == rst_at) begin
                rst = 1'b1;
                wclk(1);
                rst = 1'b0;
                wclk(4);
            end
            spi_mosi = (k < 27) ? f[26-k] : 1'b0;
            wclk(4);
            if (k == 1) chk("miso_in_hdr", 96'(spi_miso), 96'(0));
            if (k >= 3 && k < 27) rd_o[26-k] = spi_miso;
            spi_clk = 1'b1;
            wclk(4);
            spi_clk = 1'b0;
        end
        wclk(4);
        spi_csn = 1'b1;
        if (kind != K_NONE) sb.push_back('{kind, a, exp_bank, cyc + 3});
        wclk(12);
        chk("miso_idle", 96'(spi_miso), 96'(0));
    endtask

    initial begin
        vecs[0]  = '{1'b1, 2'd1, 24'h123456, 27, K_UPD,  24'h000000};
        vecs[1]  = '{1'b0, 2'd0, 24'h000000, 27, K_NONE, 24'h0CCCCC};
        vecs[2]  = '{1'b1, 2'd2, 24'hABCDEF, 20, K_ERR,  24'h000000};
        vecs[3]  = '{1'b1, 2'd2, 24'hABCDEF, 28, K_ERR,  24'h000000};
        vecs[4]  = '{1'b1, 2'd3, 24'h5A5A5A, 27, K_UPD,  24'h00001F};
        vecs[5]  = '{1'b0, 2'd3, 24'h000000, 27, K_NONE, 24'h5A5A5A};
        vecs[6]  = '{1'b0, 2'd1, 24'h000000, 27, K_NONE, 24'h123456};
        vecs[7]  = '{1'b0, 2'd2, 24'h000000, 27, K_NONE, 24'h000000};
        vecs[8]  = '{1'b1, 2'd0, 24'hFFFFFF, 27, K_UPD,  24'h0CCCCC};
        vecs[9]  = '{1'b0, 2'd0, 24'h000000, 27, K_NONE, 24'hFFFFFF};
        vecs[10] = '{1'b1, 2'd0, 24'h000000, 2,  K_ERR,  24'h000000};
        vecs[11] = '{1'b0, 2'd1, 24'h000000, 26, K_ERR,  24'h000000};

        wclk(3);
        rst = 1'b0;
        wclk(1);
        chk("reset_cfg_out", cfg_out, DEF);
        chk("reset_miso", 96'(spi_miso), 96'(0));
        chk("reset_update", 96'(cfg_update), 96'(0));
        chk("reset_frame_err", 96'(frame_err), 96'(0));
        chk("reset_cfg_addr", 96'(cfg_addr), 96'(0));
        bank_m = DEF;

        // SCK activity with CSn high must leave the block untouched
        for (int i = 0; i < 5; i++) begin
            spi_mosi = 1'b1;
            spi_clk  = 1'b1;
            wclk(4);
            spi_clk  = 1'b0;
            wclk(4);
        end
        spi_mosi = 1'b0;
        chk("sck_ignored_cfg_out", cfg_out, DEF);

        for (int v = 0; v < 12; v++) begin
            if (vecs[v].kind == K_UPD) bank_m[vecs[v].addr*24 +: 24] = vecs[v].data;
            send_frame(vecs[v].w, vecs[v].addr, vecs[v].data, vecs[v].nbits, -1,
                       vecs[v].kind, bank_m, rd);
            if (vecs[v].nbits >= 27) chk($sformatf("miso_rd_v%0d", v), 96'(rd), 96'(vecs[v].exp_rd));
            chk($sformatf("cfg_out_v%0d", v), cfg_out, bank_m);
            if (vecs[v].kind == K_UPD) chk($sformatf("cfg_addr_hold_v%0d", v), 96'(cfg_addr), 96'(vecs[v].addr));
        end

        // Reset after 10 bits with CSn held low: bank reverts, rest of frame errors
        bank_m = DEF;
        send_frame(1'b1, 2'd1, 24'h777777, 27, 10, K_ERR, DEF, rd);
        chk("rst_mid_cfg_out", cfg_out, DEF);
        chk("rst_mid_cfg_addr", 96'(cfg_addr), 96'(0));

        send_frame(1'b0, 2'd0, 24'h000000, 27, -1, K_NONE, DEF, rd);
        chk("read_after_rst", 96'(rd), 96'(24'h0CCCCC));

        wclk(4);
        chk("scoreboard_empty", 96'(sb.size()), 96'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
